// File: rtl/io_seg_pwr_pkg.sv
// Shared types and defaults for the IO-ring segment power sequencer.
// Holds the state encoding, the registered control bundle and the counter width helper.
package io_seg_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_PG   = 3'd1,
    ST_SETTLE_UP = 3'd2,
    ST_ON        = 3'd3,
    ST_SETTLE_DN = 3'd4,
    ST_FAULT     = 3'd5
  } pwr_state_e;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 16;
  localparam int DEF_SETTLE_CYC   = 8;
  localparam int DEF_TIMEOUT_CYC  = 1024;

  typedef struct packed {
    logic pad_en;
    logic io_iso;
    logic io_ret;
    logic pwr_ack;
    logic fault;
  } seg_ctl_t;

  function automatic int cnt_width(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

  // Pad controls are a pure function of the state being entered, so every
  // transition loads them on the same edge as the state register.
  function automatic seg_ctl_t ctl_of(input pwr_state_e st);
    seg_ctl_t c;
    c = '{pad_en: 1'b0, io_iso: 1'b1, io_ret: 1'b1, pwr_ack: 1'b0, fault: 1'b0};
    case (st)
      ST_SETTLE_UP, ST_SETTLE_DN: c.io_ret = 1'b0;
      ST_ON:    c = '{pad_en: 1'b1, io_iso: 1'b0, io_ret: 1'b0, pwr_ack: 1'b1, fault: 1'b0};
      ST_FAULT: c.fault = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/io_seg_sync.sv
// Level synchronizer: STAGES-flop chain, clears to 0 on reset.
// Latency STAGES cycles; no backpressure.
module io_seg_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/io_seg_pwr_seq.sv
// Power-up/down sequencer for one IO-ring segment: orders retention, isolation, enable.
// All outputs registered (1 cycle); pwr_req is a level handshake acknowledged by pwr_ack.
module io_seg_pwr_seq
  import io_seg_pwr_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  input  logic       vddio_ok,
  output logic       pwr_ack,
  output logic       pad_en,
  output logic       io_iso,
  output logic       io_ret,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  pwr_state_e       state;
  seg_ctl_t         ctl;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] deb;
  logic             pg_s;

  io_seg_sync #(.STAGES(SYNC_STAGES)) u_pg_sync (
    .clk (clk),
    .rst (rst),
    .d   (vddio_ok),
    .q   (pg_s)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // cnt is the timeout count in WAIT_PG and the settle count elsewhere;
  // deb only runs in WAIT_PG. Both clear on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF; ctl <= ctl_of(ST_OFF); cnt <= '0; deb <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (pwr_req) begin
            state <= ST_WAIT_PG; ctl <= ctl_of(ST_WAIT_PG); cnt <= '0; deb <= '0;
          end
        end
        ST_WAIT_PG: begin
          if (!pwr_req) begin
            state <= ST_OFF; ctl <= ctl_of(ST_OFF); cnt <= '0; deb <= '0;
          end else if (pg_s && deb == DEB_LAST) begin
            state <= ST_SETTLE_UP; ctl <= ctl_of(ST_SETTLE_UP); cnt <= '0; deb <= '0;
          end else if (cnt == TMO_LAST) begin
            state <= ST_FAULT; ctl <= ctl_of(ST_FAULT); cnt <= '0; deb <= '0;
          end else begin
            cnt <= sat_inc(cnt);
            deb <= pg_s ? sat_inc(deb) : '0;
          end
        end
        ST_SETTLE_UP: begin
          if (!pg_s) begin
            state <= ST_FAULT; ctl <= ctl_of(ST_FAULT); cnt <= '0;
          end else if (!pwr_req) begin
            state <= ST_SETTLE_DN; ctl <= ctl_of(ST_SETTLE_DN); cnt <= '0;
          end else if (cnt == SET_LAST) begin
            state <= ST_ON; ctl <= ctl_of(ST_ON); cnt <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_ON: begin
          if (!pg_s) begin
            state <= ST_FAULT; ctl <= ctl_of(ST_FAULT); cnt <= '0;
          end else if (!pwr_req) begin
            state <= ST_SETTLE_DN; ctl <= ctl_of(ST_SETTLE_DN); cnt <= '0;
          end
        end
        ST_SETTLE_DN: begin
          // Supply already gone: nothing left to protect, so skip the settle.
          if (!pg_s || cnt == SET_LAST) begin
            state <= ST_OFF; ctl <= ctl_of(ST_OFF); cnt <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_FAULT: begin
          if (!pwr_req) begin
            state <= ST_OFF; ctl <= ctl_of(ST_OFF); cnt <= '0;
          end
        end
        default: begin
          state <= ST_OFF; ctl <= ctl_of(ST_OFF); cnt <= '0; deb <= '0;
        end
      endcase
    end
  end

  assign pad_en  = ctl.pad_en;
  assign io_iso  = ctl.io_iso;
  assign io_ret  = ctl.io_ret;
  assign pwr_ack = ctl.pwr_ack;
  assign fault   = ctl.fault;
  assign state_o = state;

  a_en_safe: assert property (@(posedge clk) pad_en |-> (!io_iso && !io_ret));
  a_iso_ret: assert property (@(posedge clk) !io_iso |-> !io_ret);
  a_ack_on:  assert property (@(posedge clk) pwr_ack == (state == ST_ON));

endmodule

// File: tb/tb_io_seg_pwr_seq.sv
// Bench for io_seg_pwr_seq: hand-computed vector table, glitchy-supply sequence,
// and randomized traffic against a timestamp-based reference model.
module tb_io_seg_pwr_seq;

  logic       clk;
  logic       rst;
  logic       pwr_req;
  logic       vddio_ok;
  logic       pwr_ack;
  logic       pad_en;
  logic       io_iso;
  logic       io_ret;
  logic       fault;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  io_seg_pwr_seq dut (
    .clk      (clk),
    .rst      (rst),
    .pwr_req  (pwr_req),
    .vddio_ok (vddio_ok),
    .pwr_ack  (pwr_ack),
    .pad_en   (pad_en),
    .io_iso   (io_iso),
    .io_ret   (io_ret),
    .fault    (fault),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_OFF = 0, S_WAIT = 1, S_SUP = 2, S_ON = 3, S_SDN = 4, S_FLT = 5;

  // Reference model: phases tracked by entry timestamps, not counters.
  int    m_st = S_OFF;
  longint now = 0, t_enter = 0, run_start = 0;
  bit    h_old = 1'b0, h_new = 1'b0;

  task automatic model_step(input bit r, input bit q, input bit v);
    bit pg;
    longint age;
    int nxt;
    now++;
    if (r) begin
      m_st = S_OFF; h_old = 1'b0; h_new = 1'b0; t_enter = now; run_start = now;
      return;
    end
    pg = h_old; h_old = h_new; h_new = v;
    age = now - t_enter;
    nxt = m_st;
    case (m_st)
      S_OFF:  if (q) nxt = S_WAIT;
      S_WAIT: begin
        if (!pg) run_start = now;
        if (!q) nxt = S_OFF;
        else if (pg && (now - run_start) >= 16) nxt = S_SUP;
        else if (age >= 1024) nxt = S_FLT;
      end
      S_SUP:  if (!pg) nxt = S_FLT; else if (!q) nxt = S_SDN; else if (age >= 8) nxt = S_ON;
      S_ON:   if (!pg) nxt = S_FLT; else if (!q) nxt = S_SDN;
      S_SDN:  if (!pg || age >= 8) nxt = S_OFF;
      S_FLT:  if (!q) nxt = S_OFF;
      default: nxt = S_OFF;
    endcase
    if (nxt != m_st) begin
      m_st = nxt; t_enter = now; run_start = now;
    end
  endtask

  function automatic logic [7:0] exp_of(input int st);
    bit on;
    on = (st == S_ON);
    return {3'(st), on, !on, (st == S_OFF || st == S_WAIT || st == S_FLT), on, (st == S_FLT)};
  endfunction

  function automatic logic [7:0] got_v();
    return {state_o, pad_en, io_iso, io_ret, pwr_ack, fault};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got st,en,iso,ret,ack,flt=%0d,%b want %0d,%b", name, got[7:5], got[4:0], exp[7:5], exp[4:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit q, input bit v, input string tag);
    rst = r; pwr_req = q; vddio_ok = v;
    @(posedge clk);
    model_step(r, q, v);
    #1;
    check(tag, got_v(), exp_of(m_st));
  endtask

  typedef struct {
    bit r, q, v;
    int n;
    int st;
    bit en, iso, ret, ack, flt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit q, input bit v, input int n, input int st,
                              input bit en, input bit iso, input bit ret, input bit ack, input bit flt);
    vec_t t;
    t.r = r; t.q = q; t.v = v; t.n = n; t.st = st;
    t.en = en; t.iso = iso; t.ret = ret; t.ack = ack; t.flt = flt;
    return t;
  endfunction

  initial begin
    int su_at;
    int fault_seen;
    int hold_q, hold_v;
    bit rq, rv, rr;

    rst = 1'b1; pwr_req = 1'b0; vddio_ok = 1'b0;

    // reset, nominal up, orderly down with re-pulse
    tbl.push_back(mk(1,0,0,   2, 0, 0,1,1,0,0));
    tbl.push_back(mk(0,1,1,   1, 1, 0,1,1,0,0));
    tbl.push_back(mk(0,1,1,  16, 1, 0,1,1,0,0));
    tbl.push_back(mk(0,1,1,   1, 2, 0,1,0,0,0));
    tbl.push_back(mk(0,1,1,   7, 2, 0,1,0,0,0));
    tbl.push_back(mk(0,1,1,   1, 3, 1,0,0,1,0));
    tbl.push_back(mk(0,1,1,   5, 3, 1,0,0,1,0));
    tbl.push_back(mk(0,0,1,   1, 4, 0,1,0,0,0));
    tbl.push_back(mk(0,1,1,   3, 4, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,   4, 4, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,   1, 0, 0,1,1,0,0));
    // power-good timeout, fault held while requested, cleared on drop
    tbl.push_back(mk(0,1,0,   1, 1, 0,1,1,0,0));
    tbl.push_back(mk(0,1,0,1023, 1, 0,1,1,0,0));
    tbl.push_back(mk(0,1,0,   1, 5, 0,1,1,0,1));
    tbl.push_back(mk(0,1,0,   3, 5, 0,1,1,0,1));
    tbl.push_back(mk(0,0,0,   1, 0, 0,1,1,0,0));
    // up again, then brown-out with pg_s and pwr_req falling together
    tbl.push_back(mk(0,1,1,   1, 1, 0,1,1,0,0));
    tbl.push_back(mk(0,1,1,  16, 1, 0,1,1,0,0));
    tbl.push_back(mk(0,1,1,   1, 2, 0,1,0,0,0));
    tbl.push_back(mk(0,1,1,   8, 3, 1,0,0,1,0));
    tbl.push_back(mk(0,1,0,   2, 3, 1,0,0,1,0));
    tbl.push_back(mk(0,0,0,   1, 5, 0,1,1,0,1));
    tbl.push_back(mk(0,0,1,   1, 0, 0,1,1,0,0));
    // reset pulses in SETTLE_UP and in ON
    tbl.push_back(mk(0,1,1,  17, 2, 0,1,0,0,0));
    tbl.push_back(mk(1,1,1,   1, 0, 0,1,1,0,0));
    tbl.push_back(mk(0,1,1,   1, 1, 0,1,1,0,0));
    tbl.push_back(mk(0,1,1,  17, 2, 0,1,0,0,0));
    tbl.push_back(mk(0,1,1,   8, 3, 1,0,0,1,0));
    tbl.push_back(mk(1,1,1,   1, 0, 0,1,1,0,0));
    tbl.push_back(mk(0,0,1,   2, 0, 0,1,1,0,0));

    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].n; c++)
        step(tbl[k].r, tbl[k].q, tbl[k].v, $sformatf("vec%0d_model", k));
      check($sformatf("vec%0d", k), got_v(),
            {3'(tbl[k].st), tbl[k].en, tbl[k].iso, tbl[k].ret, tbl[k].ack, tbl[k].flt});
    end

    // Glitchy supply: one-cycle dropout every 10 cycles for 200 cycles.
    su_at = -1;
    fault_seen = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, !(i < 200 && (i % 10) == 9), "glitch_model");
      if (fault) fault_seen++;
      if (state_o == 3'd2 && su_at < 0) su_at = i;
    end
    check_int("glitch_settle_up_cycle", su_at, 217);
    check_int("glitch_no_fault", fault_seen, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, "glitch_down_model");
    check("glitch_down_off", got_v(), {3'd0, 5'b01100});

    // Randomized: held levels with short supply dips, rare long dips and resets.
    hold_q = 0; hold_v = 0; rq = 1'b0; rv = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (hold_q == 0) begin rq = ~rq; hold_q = $urandom_range(1, 60); end
      else hold_q--;
      if (hold_v == 0) begin
        rv = ($urandom_range(0, 3) != 0);
        hold_v = rv ? $urandom_range(5, 80) : $urandom_range(1, 6);
        if (!rv && $urandom_range(0, 24) == 0) hold_v = 1100;
      end else hold_v--;
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rq, rv, "rand_model");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
